// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: axis phase encoding, counter width and the
// default 800x600@72 timing set.
// Ports: none (package).
package vga_pkg;

    localparam int unsigned CNT_W = 11;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 56;
    localparam int unsigned DEF_H_SYNC   = 120;
    localparam int unsigned DEF_H_BP     = 64;

    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 37;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BP     = 23;

    localparam logic DEF_SYNC_POL = 1'b1;

endpackage

// File: rtl/vga_timing_if.sv
// Bundle between the timing generator and the pixel source / VGA DAC.
// Signals:
//   col, row          current horizontal / vertical position
//   tetris_red/green/blue  colour returned combinationally for col/row
//   VGA_R/G/B         registered pixel colour
//   VGA_HS/VGA_VS     registered sync
//   VGA_BLANK_N       registered, high while the pixel is visible
//   frame_start       one-cycle pulse at frame wrap
// Modports: master = timing generator, slave = pixel source / consumer.
interface vga_timing_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [7:0]       tetris_red;
    logic [7:0]       tetris_green;
    logic [7:0]       tetris_blue;
    logic [7:0]       VGA_R;
    logic [7:0]       VGA_G;
    logic [7:0]       VGA_B;
    logic             VGA_HS;
    logic             VGA_VS;
    logic             VGA_BLANK_N;
    logic             frame_start;

    modport master (
        output col, row, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
        input  tetris_red, tetris_green, tetris_blue
    );

    modport slave (
        input  col, row, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
        output tetris_red, tetris_green, tetris_blue
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Ports:
//   clk     clock
//   reset   synchronous active-high reset (count 0, phase ACTIVE)
//   enable  advance by one position this clock
//   count   current position, 0 .. ACTIVE+FP+SYNC+BP-1
//   phase   current phase, always consistent with count
//   wrap    combinational: enabled and at the last position of the axis
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             wrap
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_POS    = CNT_W'(TOTAL - 1);

    assign wrap = enable && (count == LAST_POS);

    // Counter and phase advance together so the phase never disagrees with count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else if (enable) begin
            count <= wrap ? '0 : count + CNT_W'(1);
            case (phase)
                PH_ACTIVE: if (count == LAST_ACTIVE) phase <= PH_FRONT;
                PH_FRONT:  if (count == LAST_FRONT)  phase <= PH_SYNC;
                PH_SYNC:   if (count == LAST_SYNC)   phase <= PH_BACK;
                PH_BACK:   if (count == LAST_POS)    phase <= PH_ACTIVE;
                default:   phase <= PH_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: horizontal and vertical axis counters, with colour,
// sync, blanking and frame pulse all registered one clock after the col/row
// that produced them.
// Ports:
//   CLOCK_50  pixel clock
//   reset     synchronous active-high reset
//   vga       vga_timing_if master: col/row out, tetris_* colour in,
//             VGA_* and frame_start out
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    vga_timing_if.master  vga
);

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic             visible_c;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (CLOCK_50),
        .reset  (reset),
        .enable (1'b1),
        .count  (hc),
        .phase  (h_phase),
        .wrap   (h_wrap)
    );

    // Vertical axis steps once per line, on the last pixel of the line.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (CLOCK_50),
        .reset  (reset),
        .enable (h_wrap),
        .count  (vc),
        .phase  (v_phase),
        .wrap   (v_wrap)
    );

    assign vga.col   = hc;
    assign vga.row   = vc;
    assign visible_c = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

    // Output stage: one register for every VGA_* so colour and sync stay aligned.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vga.VGA_R       <= 8'd0;
            vga.VGA_G       <= 8'd0;
            vga.VGA_B       <= 8'd0;
            vga.VGA_BLANK_N <= 1'b0;
            vga.VGA_HS      <= ~SYNC_POL;
            vga.VGA_VS      <= ~SYNC_POL;
            vga.frame_start <= 1'b0;
        end else begin
            vga.VGA_R       <= visible_c ? vga.tetris_red   : 8'd0;
            vga.VGA_G       <= visible_c ? vga.tetris_green : 8'd0;
            vga.VGA_B       <= visible_c ? vga.tetris_blue  : 8'd0;
            vga.VGA_BLANK_N <= visible_c;
            vga.VGA_HS      <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vga.VGA_VS      <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            // v_wrap already implies hc at end of line and vc at end of frame.
            vga.frame_start <= v_wrap;
        end
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 H_ACTIVE, 800, visible pixels per line.
REQ-002 H_FP / H_SYNC / H_BP, 56 / 120 / 64, horizontal front porch / sync / back porch in clocks; line total 1040.
REQ-003 V_ACTIVE, 600, visible lines per frame.
REQ-004 V_FP / V_SYNC / V_BP, 37 / 6 / 23, vertical porch/sync lengths in lines; frame total 666.
REQ-005 SYNC_POL, 1'b1, asserted level of VGA_HS/VGA_VS.
REQ-006 CLOCK_50  input  1  sole clock, also the pixel clock; one clock; reset is synchronous and active-high.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 tetris_red, tetris_green, tetris_blue  input  8 each  combinational pixel colour returned for current col/row.
REQ-009 col, row  output  11 each  current horizontal/vertical counter values.
REQ-010 VGA_R, VGA_G, VGA_B  output  8 each  registered pixel colour.
REQ-011 VGA_HS, VGA_VS  output  1 each  registered sync.
REQ-012 VGA_BLANK_N  output  1  registered, high while pixel visible.
REQ-013 frame_start  output  1  one-cycle pulse at frame wrap, for game-logic pacing.

Function
REQ-014 Horizontal counter hc SHALL count 0..1039, incrementing every clock, wrapping 1039->0.
REQ-015 Vertical counter vc SHALL increment only on the clock where hc==1039, count 0..665, wrap 665->0.
REQ-016 col SHALL equal hc and row SHALL equal vc directly from registers, including during blanking (col up to 1039, row up to 665).
REQ-017 Each axis SHALL run a phase FSM ACTIVE->FRONT->SYNC->BACK->ACTIVE; horizontal transitions on hc==799, 855, 975, 1039; vertical on vc==599, 636, 642, 665 qualified by hc==1039.
REQ-018 Phase FSM state SHALL always agree with counter decode (ACTIVE: hc 0..799; FRONT 800..855; SYNC 856..975; BACK 976..1039; vertical analogous).
REQ-019 All VGA_* outputs SHALL have exactly one clock latency from the col/row that produced them, keeping colour and sync aligned.
REQ-020 VGA_BLANK_N SHALL register (h ACTIVE && v ACTIVE).
REQ-021 VGA_R/G/B SHALL register tetris_* when visible, else 8'd0.
REQ-022 VGA_HS SHALL register SYNC_POL when h phase is SYNC, else ~SYNC_POL; VGA_VS likewise from v phase, independent of h phase.
REQ-023 frame_start SHALL register 1 when hc==1039 && vc==665, else 0; thus high on the cycle col/row read 0/0.
REQ-024 Counter arithmetic SHALL be 11-bit unsigned; no state outside listed ranges reachable.

Reset
REQ-025 While reset is high at a clock edge: hc=0, vc=0, both FSMs ACTIVE, VGA_R/G/B=0, VGA_BLANK_N=0, VGA_HS=VGA_VS=~SYNC_POL, frame_start=0.
REQ-026 Reset asserted mid-line or mid-frame SHALL take effect at the next edge with no partial sync pulse extended beyond it.
REQ-027 First edge after reset release SHALL advance hc 0->1 and register visible pixel (0,0).

Structure
REQ-028 Package vga_pkg SHALL hold phase_t enum (ACTIVE, FRONT, SYNC, BACK) and default timing constants; color_t stays in the existing colour package.
REQ-029 One sub-module, vga_axis_counter (parameters ACTIVE/FP/SYNC/BP; inputs clock, reset, enable; outputs count, phase, wrap), SHALL be instantiated twice: horizontal (enable=1) and vertical (enable=horizontal wrap).

Verification
REQ-030 Reset held 5 cycles mid-frame -> all outputs at REQ-025 values, col=row=0 on release.
REQ-031 Release reset, count edges -> VGA_HS rises on edge 857, stays high exactly 120 clocks; period 1040.
REQ-032 Run full frame -> VGA_VS high exactly 6*1040=6240 clocks, rising 637*1040+1 edges after release; frame period 692640.
REQ-033 Drive tetris_* = {col[7:0], row[7:0], 8'hA5} -> VGA_R/G/B one cycle later match for visible pixels, 0 when col>=800 or row>=600.
REQ-034 Observe frame_start -> exactly one pulse per 692640 clocks, coincident with col=row=0.
REQ-035 Assert reset during vertical SYNC -> VGA_VS deasserts next edge; next VS pulse full 6 lines.
